param_sequencer: RTL and testbench
==================================

// Module: param_sequencer
// PURPOSE
//  Parametrised major-state/phase sequencer for the PDP-8 core; generalises the fixed 32-step timing chain.
//  Step = PHASES clocks per slot: FETCH, NOPT skippable slots (autoinc/indirect), NEXEC execute slots, TAIL idle steps.
//  Adds run/halt/step-instruction/step-micro control FSM, per-slot skip mask, early END_REQ, INSTR_DONE pulse.
// PARAMETERS
//  PHASES     3  clocks (steps) per slot; one-hot PH width
//  NOPT       3  optional slots after FETCH (slot 1..NOPT), skippable via SKIP mask
//  NEXEC      6  execute slots (slot NOPT+1..NOPT+NEXEC)
//  TAIL       2  idle steps after last slot before wrap (no CK/STB asserted)
//  STB_PHASE  1  phase index (0..PHASES-1) on which a slot's STB fires
// PORTS
//  CLK        in   1  PDP clock; all state updates on rising edge
//  CLEAR      in   1  synchronous, active-high reset
//  RUN        in   1  rising edge: start continuous run
//  HALT       in   1  rising edge: stop at end of current instruction
//  STEPI      in   1  rising edge: execute one full instruction
//  STEPM      in   1  rising edge: execute one step
//  SKIP       in   NOPT  bit k=1 skips slot k+1; sampled on last step of FETCH
//  END_REQ    in   1  sampled on last step of an execute slot: jump to TAIL
//  PH         out  PHASES  one-hot phase of current step
//  CK         out  1+NOPT+NEXEC  one-hot active slot (bit 0 = FETCH); all-zero in TAIL
//  STB        out  1+NOPT+NEXEC  CK[s] & (phase==STB_PHASE)
//  STEP_CNT   out  SW  linear step index, SW=$clog2(NSTEP), NSTEP=PHASES*(1+NOPT+NEXEC)+TAIL
//  RUNNING    out  1  FSM not in STOPPED
//  INSTR_DONE out  1  one-clock pulse on the step that wraps NSTEP-1 -> 0
// BEHAVIOUR
//  Reset (CLEAR=1): STEP_CNT=0, FSM=STOPPED, skip latch=0, edge regs=0; PH=1, CK=1 (FETCH), STB=0, RUNNING=0, INSTR_DONE=0.
//  Edge detect: registered previous value per control input; edge = in & ~prev. Inputs pre-synchronised to CLK.
//  FSM STOPPED: RUN edge->RUN_CONT; else STEPI edge->RUN_STEPI; else STEPM edge -> advance exactly one step, stay STOPPED.
//  FSM RUN_CONT: advance every clock; HALT edge sets halt_pend (held until used); at wrap: halt_pend -> STOPPED, clear.
//  FSM RUN_STEPI: advance every clock; at wrap -> STOPPED; RUN edge -> RUN_CONT (no stop). HALT edge -> halt_pend.
//  Simultaneous edges same clock: HALT > RUN > STEPI > STEPM; STEPM ignored unless STOPPED.
//  HALT edge while STOPPED: no effect (halt_pend not set). Stop always lands at STEP_CNT=0 except after STEPM.
//  Advance: within slot, STEP_CNT+1. Last step of FETCH: latch SKIP; next = first slot k in 1..NOPT with ~SKIP[k-1], else first exec slot.
//   Last step of optional slot k: next = first non-skipped optional slot >k, else first exec slot.
//   Last step of exec slot: END_REQ=1 -> first TAIL step; else next slot (last exec -> TAIL). Last TAIL step -> 0, INSTR_DONE=1.
//  Latency: control edge at clock n changes FSM at n+1; first advance at n+1 edge. Outputs are pure decode of STEP_CNT (no extra latency).
//  TAIL=0: last exec slot wraps directly to 0. STEPM mid-instruction then STEPI: continues from current step to wrap.
//  CLEAR mid-instruction: immediate return to reset state next edge; pending edges discarded.
// CONFIGURATION
//  SEQ_BKPT_EN defined: extra ports BKPT_EN in 1, BKPT_SLOT in $clog2(1+NOPT+NEXEC); when RUN_CONT/RUN_STEPI
//   is about to enter phase 0 of BKPT_SLOT with BKPT_EN=1, FSM -> STOPPED without advancing; next RUN/STEPI resumes into it.
//  SEQ_BKPT_EN undefined: ports absent, no breakpoint logic; behaviour identical to BKPT_EN=0.
// STRUCTURE
//  Shared package seq_pkg: FSM state enum (STOPPED, RUN_CONT, RUN_STEPI), slot index constants SLOT_FETCH, SLOT_OPT0, SLOT_EXEC0.
//  One sub-module: seq_edge_det (per-bit rising-edge detector, width parameter), instanced once for {HALT,RUN,STEPI,STEPM}.
//  Next-slot priority search and output decode in this module.
// TESTING (defaults: NSTEP=32)
//  CLEAR then RUN pulse, SKIP=0, END_REQ=0 -> STEP_CNT 0..31 consecutively, INSTR_DONE at 31->0, STB[0] at step 1, STB[9] at 28.
//  SKIP=3'b011 latched at step 2 -> step 2 followed by 9 (slot 3 only); SKIP=3'b111 -> 2 followed by 12.
//  END_REQ=1 on step 17 (exec slot 5 last step) -> next step 30, then 31, 0 with INSTR_DONE.
//  STOPPED, STEPM pulse x3 -> STEP_CNT 0->1->2->3, RUNNING stays 0; then STEPI -> runs to 0, stops, INSTR_DONE once.
//  RUN_CONT, HALT pulse at step 5 -> continues to 31, stops at 0; RUN+HALT same clock while STOPPED -> stays STOPPED.
//  CLEAR at step 20 while running -> next clock STEP_CNT=0, RUNNING=0, CK=1, STB=0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and slot constants for the parametrised PDP-8 major-state sequencer.
package seq_pkg;

   typedef enum logic [1:0] {STOPPED, RUN_CONT, RUN_STEPI} seq_state_e;

   localparam int unsigned SLOT_FETCH = 0;
   localparam int unsigned SLOT_OPT0  = 1;

   function automatic int unsigned slot_exec0(input int unsigned nopt);
      return SLOT_OPT0 + nopt;
   endfunction

   function automatic int unsigned seq_nstep(input int unsigned phases, input int unsigned nopt,
                                             input int unsigned nexec, input int unsigned tail);
      return phases * (1 + nopt + nexec) + tail;
   endfunction

endpackage

// File: rtl/param_sequencer_if.sv
// Control/status bundle of param_sequencer; SEQ_BKPT_EN adds the breakpoint inputs.
interface param_sequencer_if #(
   parameter int unsigned PHASES = 3,
   parameter int unsigned NOPT   = 3,
   parameter int unsigned NEXEC  = 6,
   parameter int unsigned TAIL   = 2
) ();
   localparam int unsigned NSLOT = 1 + NOPT + NEXEC;
   localparam int unsigned SW    = $clog2(seq_pkg::seq_nstep(PHASES, NOPT, NEXEC, TAIL));

   logic              RUN;
   logic              HALT;
   logic              STEPI;
   logic              STEPM;
   logic [NOPT-1:0]   SKIP;
   logic              END_REQ;
   logic [PHASES-1:0] PH;
   logic [NSLOT-1:0]  CK;
   logic [NSLOT-1:0]  STB;
   logic [SW-1:0]     STEP_CNT;
   logic              RUNNING;
   logic              INSTR_DONE;

`ifdef SEQ_BKPT_EN
   logic                     BKPT_EN;
   logic [$clog2(NSLOT)-1:0] BKPT_SLOT;

   modport master (output RUN, HALT, STEPI, STEPM, SKIP, END_REQ, BKPT_EN, BKPT_SLOT,
                   input  PH, CK, STB, STEP_CNT, RUNNING, INSTR_DONE);
   modport slave  (input  RUN, HALT, STEPI, STEPM, SKIP, END_REQ, BKPT_EN, BKPT_SLOT,
                   output PH, CK, STB, STEP_CNT, RUNNING, INSTR_DONE);
`else
   modport master (output RUN, HALT, STEPI, STEPM, SKIP, END_REQ,
                   input  PH, CK, STB, STEP_CNT, RUNNING, INSTR_DONE);
   modport slave  (input  RUN, HALT, STEPI, STEPM, SKIP, END_REQ,
                   output PH, CK, STB, STEP_CNT, RUNNING, INSTR_DONE);
`endif

endinterface

// File: rtl/seq_edge_det.sv
// Per-bit rising-edge detector for pre-synchronised control inputs.
module seq_edge_det #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CLK,
   input  logic             CLEAR,
   input  logic [WIDTH-1:0] sig_i,
   output logic [WIDTH-1:0] rise_o
);

   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge CLK) begin
      if (CLEAR) prev_q <= '0;
      else       prev_q <= sig_i;
   end

   assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/param_sequencer.sv
// Parametrised PDP-8 major-state/phase sequencer with run/halt/step control.
// Optional breakpoint support is compiled in with `define SEQ_BKPT_EN.
module param_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned PHASES    = 3,
   parameter int unsigned NOPT      = 3,
   parameter int unsigned NEXEC     = 6,
   parameter int unsigned TAIL      = 2,
   parameter int unsigned STB_PHASE = 1
) (
   input logic               CLK,
   input logic               CLEAR,
   param_sequencer_if.slave  bus
);

   localparam int unsigned NSLOT      = 1 + NOPT + NEXEC;
   localparam int unsigned NBODY      = PHASES * NSLOT;
   localparam int unsigned NSTEP      = seq_nstep(PHASES, NOPT, NEXEC, TAIL);
   localparam int unsigned SW         = $clog2(NSTEP);
   localparam int unsigned SLOT_EXEC0 = slot_exec0(NOPT);

   seq_state_e      state_q;
   logic [SW-1:0]   step_q, step_nxt;
   logic [NOPT-1:0] skip_q;
   logic            halt_pend_q, done_q;
   logic [3:0]      rise;
   logic            halt_e, run_e, stepi_e, stepm_e;
   int unsigned     step_i, slot_i, phase_i, nxt;
   logic            fetch_end, wrap, adv, bkpt_hit;

   seq_edge_det #(
      .WIDTH (4)
   ) u_edge (
      .CLK    (CLK),
      .CLEAR  (CLEAR),
      .sig_i  ({bus.HALT, bus.RUN, bus.STEPI, bus.STEPM}),
      .rise_o (rise)
   );

   assign {halt_e, run_e, stepi_e, stepm_e} = rise;

   // Lowest-numbered optional slot above `from` that is not skipped, else the first exec slot.
   function automatic int unsigned next_opt(input int unsigned from, input logic [NOPT-1:0] sk);
      next_opt = SLOT_EXEC0;
      for (int unsigned k = NOPT; k >= 1; k--) begin
         if (k > from && !sk[k-1]) next_opt = k;
      end
   endfunction

   always_comb begin
      step_i  = 32'(step_q);
      slot_i  = step_i / PHASES;
      phase_i = step_i % PHASES;
      for (int unsigned p = 0; p < PHASES; p++) bus.PH[p] = (phase_i == p);
      for (int unsigned s = 0; s < NSLOT; s++) begin
         bus.CK[s]  = (step_i < NBODY) && (slot_i == s);
         bus.STB[s] = (step_i < NBODY) && (slot_i == s) && (phase_i == STB_PHASE);
      end
   end

   always_comb begin
      nxt       = step_i + 1;
      fetch_end = 1'b0;
      if (step_i < NBODY && phase_i == PHASES - 1) begin
         if (slot_i == SLOT_FETCH) begin
            fetch_end = 1'b1;
            nxt       = PHASES * next_opt(SLOT_FETCH, bus.SKIP);
         end else if (slot_i < SLOT_EXEC0) begin
            nxt = PHASES * next_opt(slot_i, skip_q);
         end else if (bus.END_REQ) begin
            nxt = NBODY;
         end else begin
            nxt = PHASES * (slot_i + 1);
         end
      end
      // Covers both the last TAIL step and TAIL=0 exits from the exec slots.
      if (nxt >= NSTEP) nxt = 0;
      wrap     = (nxt == 0);
      step_nxt = SW'(nxt);
   end

`ifdef SEQ_BKPT_EN
   logic bkpt_resume_q;

   // The resume flag lets the first advance after a breakpoint stop enter the slot.
   assign bkpt_hit = (state_q != STOPPED) && bus.BKPT_EN && !bkpt_resume_q &&
                     (nxt == PHASES * 32'(bus.BKPT_SLOT));

   always_ff @(posedge CLK) begin
      if (CLEAR)         bkpt_resume_q <= 1'b0;
      else if (bkpt_hit) bkpt_resume_q <= 1'b1;
      else if (adv)      bkpt_resume_q <= 1'b0;
   end
`else
   assign bkpt_hit = 1'b0;
`endif

   assign adv = !bkpt_hit &&
                ((state_q != STOPPED) || (!halt_e && !run_e && !stepi_e && stepm_e));

   always_ff @(posedge CLK) begin
      if (CLEAR) begin
         state_q     <= STOPPED;
         step_q      <= '0;
         skip_q      <= '0;
         halt_pend_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= adv && wrap;
         if (adv) begin
            step_q <= step_nxt;
            if (fetch_end) skip_q <= bus.SKIP;
         end
         case (state_q)
            STOPPED: begin
               if (!halt_e && run_e)        state_q <= RUN_CONT;
               else if (!halt_e && stepi_e) state_q <= RUN_STEPI;
            end
            RUN_CONT: begin
               if (halt_e) halt_pend_q <= 1'b1;
               if (adv && wrap && (halt_pend_q || halt_e)) begin
                  state_q     <= STOPPED;
                  halt_pend_q <= 1'b0;
               end
            end
            RUN_STEPI: begin
               if (halt_e) halt_pend_q <= 1'b1;
               if (!halt_e && run_e) begin
                  state_q <= RUN_CONT;
               end else if (adv && wrap) begin
                  state_q     <= STOPPED;
                  halt_pend_q <= 1'b0;
               end
            end
            default: state_q <= STOPPED;
         endcase
         if (bkpt_hit) state_q <= STOPPED;
      end
   end

   assign bus.STEP_CNT   = step_q;
   assign bus.RUNNING    = (state_q != STOPPED);
   assign bus.INSTR_DONE = done_q;

endmodule

// File: tb/tb_param_sequencer.sv
// Randomised bench for param_sequencer against a slot-queue reference model.
module tb_param_sequencer;

   localparam int PHASES    = 3;
   localparam int NOPT      = 3;
   localparam int NEXEC     = 6;
   localparam int TAIL      = 2;
   localparam int STB_PHASE = 1;
   localparam int NSLOT     = 1 + NOPT + NEXEC;
   localparam int NBODY     = PHASES * NSLOT;
   localparam int NSTEP     = NBODY + TAIL;

   logic CLK = 1'b0;
   logic CLEAR;

   param_sequencer_if bus ();

   param_sequencer dut (
      .CLK   (CLK),
      .CLEAR (CLEAR),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Model: current slot (-1 = tail) and phase, plus the queue of slots still to visit.
   int       m_slot, m_ph, m_tail, m_mode;
   bit       m_pend, m_done;
   bit [3:0] m_prev;
   int       m_queue[$];

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int m_step();
      return (m_slot >= 0) ? m_slot * PHASES + m_ph : NBODY + m_tail;
   endfunction

   function automatic void model_reset();
      m_slot = 0; m_ph = 0; m_tail = 0; m_mode = 0;
      m_pend = 0; m_done = 0; m_prev = '0;
      m_queue.delete();
   endfunction

   // Returns 1 when this advance completes the instruction.
   function automatic bit model_advance();
      int sk;
      if (m_slot < 0) begin
         m_tail++;
         if (m_tail == TAIL) begin m_slot = 0; m_ph = 0; return 1'b1; end
         return 1'b0;
      end
      if (m_ph < PHASES - 1) begin m_ph++; return 1'b0; end
      if (m_slot == 0) begin
         sk = int'(bus.SKIP);
         m_queue.delete();
         for (int k = 1; k <= NOPT; k++) if (((sk >> (k - 1)) & 1) == 0) m_queue.push_back(k);
         for (int e = 0; e < NEXEC; e++) m_queue.push_back(1 + NOPT + e);
      end else if (m_slot > NOPT && bus.END_REQ) begin
         m_queue.delete();
      end
      if (m_queue.size() > 0) begin
         m_slot = m_queue.pop_front();
         m_ph   = 0;
         return 1'b0;
      end
      if (TAIL == 0) begin m_slot = 0; m_ph = 0; return 1'b1; end
      m_slot = -1; m_tail = 0;
      return 1'b0;
   endfunction

   function automatic void model_tick();
      bit he, re, se, me, adv, wr;
      int old;
      if (CLEAR) begin model_reset(); return; end
      he  = bus.HALT  && !m_prev[3];
      re  = bus.RUN   && !m_prev[2];
      se  = bus.STEPI && !m_prev[1];
      me  = bus.STEPM && !m_prev[0];
      old = m_mode;
      adv = 0;
      wr  = 0;
      if (old == 0) begin
         if (!he && re)      m_mode = 1;
         else if (!he && se) m_mode = 2;
         else if (!he && me) adv = 1;
      end else if (old == 1) begin
         adv = 1;
         if (he) m_pend = 1;
      end else begin
         adv = 1;
         if (he) m_pend = 1;
         else if (re) m_mode = 1;
      end
      if (adv) wr = model_advance();
      if (wr && old == 1 && m_pend)      begin m_mode = 0; m_pend = 0; end
      if (wr && old == 2 && m_mode == 2) begin m_mode = 0; m_pend = 0; end
      m_done = wr;
      m_prev = {bus.HALT, bus.RUN, bus.STEPI, bus.STEPM};
   endfunction

   task automatic check_outputs();
      int ck_exp, ph_exp, stb_exp;
      ck_exp  = (m_slot >= 0) ? (1 << m_slot) : 0;
      ph_exp  = 1 << (m_step() % PHASES);
      stb_exp = (m_slot >= 0 && m_ph == STB_PHASE) ? ck_exp : 0;
      check_eq("step",    int'(bus.STEP_CNT),   m_step());
      check_eq("running", int'(bus.RUNNING),    int'(m_mode != 0));
      check_eq("done",    int'(bus.INSTR_DONE), int'(m_done));
      check_eq("ph",      int'(bus.PH),         ph_exp);
      check_eq("ck",      int'(bus.CK),         ck_exp);
      check_eq("stb",     int'(bus.STB),        stb_exp);
   endtask

   task automatic tick();
      model_tick();
      @(negedge CLK);
      check_outputs();
   endtask

   task automatic run_until(input int target);
      int n = 0;
      while (m_step() != target && n < 200) begin tick(); n++; end
      check_eq("reach", int'(bus.STEP_CNT), target);
   endtask

   initial begin
      int done_cnt;
      int n;
      CLEAR = 1'b1;
      bus.RUN = 0; bus.HALT = 0; bus.STEPI = 0; bus.STEPM = 0;
      bus.SKIP = '0; bus.END_REQ = 0;
      tick();
      tick();
      check_eq("rst_step", int'(bus.STEP_CNT), 0);
      check_eq("rst_ck",   int'(bus.CK), 1);
      check_eq("rst_stb",  int'(bus.STB), 0);
      check_eq("rst_run",  int'(bus.RUNNING), 0);
      CLEAR = 1'b0;

      // Continuous run over one full instruction.
      bus.RUN = 1; tick(); bus.RUN = 0;
      for (int k = 1; k <= NSTEP; k++) begin
         tick();
         check_eq("cont_seq", int'(bus.STEP_CNT), k % NSTEP);
         if (k == 1)  check_eq("stb0_at1",  int'(bus.STB), 1);
         if (k == 28) check_eq("stb9_at28", int'(bus.STB), 1 << 9);
      end
      check_eq("cont_done", int'(bus.INSTR_DONE), 1);

      bus.SKIP = 3'b011; run_until(2); tick();
      check_eq("skip011", int'(bus.STEP_CNT), 9);
      bus.SKIP = 3'b111; run_until(2); tick();
      check_eq("skip111", int'(bus.STEP_CNT), 12);
      bus.SKIP = '0;

      run_until(17); bus.END_REQ = 1; tick(); bus.END_REQ = 0;
      check_eq("endreq_30", int'(bus.STEP_CNT), 30);
      tick(); check_eq("endreq_31", int'(bus.STEP_CNT), 31);
      tick(); check_eq("endreq_0", int'(bus.STEP_CNT), 0);
      check_eq("endreq_done", int'(bus.INSTR_DONE), 1);

      run_until(5); bus.HALT = 1; tick(); bus.HALT = 0;
      run_until(0);
      repeat (3) tick();
      check_eq("halt_run", int'(bus.RUNNING), 0);
      check_eq("halt_step", int'(bus.STEP_CNT), 0);

      bus.RUN = 1; bus.HALT = 1; tick(); bus.RUN = 0; bus.HALT = 0;
      tick(); tick();
      check_eq("runhalt_run", int'(bus.RUNNING), 0);

      for (int k = 1; k <= 3; k++) begin
         bus.STEPM = 1; tick(); bus.STEPM = 0; tick();
         check_eq("stepm_step", int'(bus.STEP_CNT), k);
         check_eq("stepm_run", int'(bus.RUNNING), 0);
      end
      bus.STEPI = 1; tick(); bus.STEPI = 0;
      done_cnt = 0;
      n = 0;
      while (m_mode != 0 && n < 100) begin tick(); done_cnt += int'(bus.INSTR_DONE); n++; end
      repeat (3) begin tick(); done_cnt += int'(bus.INSTR_DONE); end
      check_eq("stepi_done", done_cnt, 1);
      check_eq("stepi_step", int'(bus.STEP_CNT), 0);
      check_eq("stepi_run", int'(bus.RUNNING), 0);

      bus.RUN = 1; tick(); bus.RUN = 0;
      run_until(20);
      CLEAR = 1; tick(); CLEAR = 0;
      check_eq("clr_step", int'(bus.STEP_CNT), 0);
      check_eq("clr_run", int'(bus.RUNNING), 0);
      check_eq("clr_ck", int'(bus.CK), 1);
      check_eq("clr_stb", int'(bus.STB), 0);

      for (int i = 0; i < 4000; i++) begin
         bus.RUN     = ($urandom_range(0, 19) == 0);
         bus.HALT    = ($urandom_range(0, 29) == 0);
         bus.STEPI   = ($urandom_range(0, 24) == 0);
         bus.STEPM   = ($urandom_range(0, 3) == 0);
         bus.SKIP    = NOPT'($urandom);
         bus.END_REQ = ($urandom_range(0, 5) == 0);
         CLEAR       = ($urandom_range(0, 299) == 0);
         tick();
      end
      CLEAR = 0; bus.RUN = 0; bus.HALT = 0; bus.STEPI = 0; bus.STEPM = 0; bus.END_REQ = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
